// File: rtl/sram_mem_controller.sv
// Splits each 32-bit MEM-stage access into two half-word phases on a 16-bit async SRAM,
// holding ready low until the access completes.
module sram_mem_controller #(
  parameter int unsigned ADDR_BASE   = 1024,
  parameter int unsigned WAIT_CYCLES = 3,
  parameter int unsigned SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_we_n
);

  localparam int unsigned CNT_W  = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam int unsigned WORD_W = SRAM_AW - 1;

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               wr_q, wr_d;
  logic [WORD_W-1:0]  word_q, word_d;
  logic [31:0]        wd_q, wd_d;
  logic [31:0]        offset;
  logic               req, last;
  logic [31:0]        read_data_d;
  logic [SRAM_AW-1:0] sram_addr_d;
  logic [15:0]        sram_dq_out_d;
  logic               sram_dq_oe_d, sram_we_n_d;
  logic               unused_offset_bits;

  assign req    = rd_en | wr_en;
  assign offset = address - 32'(ADDR_BASE);
  assign last   = (cnt_q == CNT_W'(WAIT_CYCLES - 1));
  assign ready  = ((state_q == IDLE) && !req) || (state_q == DONE);

  // Word index bits above the SRAM range and the byte offset are intentionally dropped.
  assign unused_offset_bits = ^{offset[31:SRAM_AW+1], offset[1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next state, latched request, and pin values for the state being entered.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    wr_d          = wr_q;
    word_d        = word_q;
    wd_d          = wd_q;
    read_data_d   = read_data;
    sram_addr_d   = sram_addr;
    sram_dq_out_d = sram_dq_out;
    sram_dq_oe_d  = 1'b0;
    sram_we_n_d   = 1'b1;

    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = LOW;
          cnt_d   = '0;
          wr_d    = wr_en;
          word_d  = offset[SRAM_AW:2];
          wd_d    = write_data;
        end
      end
      LOW: begin
        if (last) begin
          state_d = HIGH;
          cnt_d   = '0;
          if (!wr_q) read_data_d[15:0] = sram_dq_in;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HIGH: begin
        if (last) begin
          state_d = DONE;
          cnt_d   = '0;
          if (!wr_q) read_data_d[31:16] = sram_dq_in;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if ((state_d == LOW) || (state_d == HIGH)) begin
      sram_addr_d = {word_d, (state_d == HIGH)};
      if (wr_d) begin
        sram_dq_oe_d  = 1'b1;
        sram_we_n_d   = 1'b0;
        sram_dq_out_d = (state_d == HIGH) ? wd_d[31:16] : wd_d[15:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q       <= '0;
      wr_q        <= 1'b0;
      word_q      <= '0;
      wd_q        <= '0;
      read_data   <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
    end else begin
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      word_q      <= word_d;
      wd_q        <= wd_d;
      read_data   <= read_data_d;
      sram_addr   <= sram_addr_d;
      sram_dq_out <= sram_dq_out_d;
      sram_dq_oe  <= sram_dq_oe_d;
      sram_we_n   <= sram_we_n_d;
    end
  end

endmodule

// File: tb/tb_sram_mem_controller.sv
// Directed bench for sram_mem_controller with a small behavioural SRAM model.
module tb_sram_mem_controller;

  localparam int unsigned W  = 3;
  localparam int unsigned AW = 18;

  logic          clk;
  logic          rst;
  logic          rd_en, wr_en;
  logic [31:0]   address, write_data, read_data;
  logic          ready;
  logic [AW-1:0] sram_addr;
  logic [15:0]   sram_dq_out, sram_dq_in;
  logic          sram_dq_oe, sram_we_n;

  logic [15:0]   mem [0:63];
  int            n_tests;
  int            n_fail;

  sram_mem_controller #(.ADDR_BASE(1024), .WAIT_CYCLES(W), .SRAM_AW(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .rd_en       (rd_en),
    .wr_en       (wr_en),
    .address     (address),
    .write_data  (write_data),
    .read_data   (read_data),
    .ready       (ready),
    .sram_addr   (sram_addr),
    .sram_dq_out (sram_dq_out),
    .sram_dq_oe  (sram_dq_oe),
    .sram_dq_in  (sram_dq_in),
    .sram_we_n   (sram_we_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Async SRAM: reads follow the address bus, writes land while the strobe is low.
  always_comb sram_dq_in = mem[sram_addr[5:0]];
  always @(negedge clk) begin
    if (!sram_we_n && sram_dq_oe) mem[sram_addr[5:0]] = sram_dq_out;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Entered just after a rising edge; walks the request cycle through DONE.
  task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] exp_rd);
    logic [16:0] word;
    logic        lo, hi, drv;
    word       = 17'((addr - 32'd1024) >> 2);
    rd_en      = rd;
    wr_en      = wr;
    address    = addr;
    write_data = wd;
    for (int c = 0; c <= 2 * W + 1; c++) begin
      @(negedge clk);
      lo  = (c >= 1) && (c <= W);
      hi  = (c > W) && (c <= 2 * W);
      drv = wr && (lo || hi);
      check("ready", 32'(ready), 32'(c == 2 * W + 1));
      check("dq_oe", 32'(sram_dq_oe), 32'(drv));
      check("we_n", 32'(sram_we_n), 32'(!drv));
      if (lo) check("addr_low", 32'(sram_addr), 32'({word, 1'b0}));
      if (hi) check("addr_high", 32'(sram_addr), 32'({word, 1'b1}));
      if (drv && lo) check("dq_out_low", 32'(sram_dq_out), 32'(wd[15:0]));
      if (drv && hi) check("dq_out_high", 32'(sram_dq_out), 32'(wd[31:16]));
      if (c == 2 * W + 1) check("read_data", read_data, exp_rd);
      @(posedge clk);
      #1;
    end
    rd_en = 1'b0;
    wr_en = 1'b0;
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    for (int i = 0; i < 64; i++) mem[i] = 16'hA000 + 16'(i);
    rst        = 1'b0;
    rd_en      = 1'b0;
    wr_en      = 1'b0;
    address    = '0;
    write_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_read_data", read_data, 32'h0);
    check("rst_sram_addr", 32'(sram_addr), 32'h0);
    check("rst_dq_out", 32'(sram_dq_out), 32'h0);
    rst = 1'b1;

    // Idle with no request
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_ready", 32'(ready), 32'h1);
      check("idle_we_n", 32'(sram_we_n), 32'h1);
      check("idle_oe", 32'(sram_dq_oe), 32'h0);
    end
    @(posedge clk);
    #1;

    access(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 32'h0);
    @(negedge clk);
    check("post_write_ready", 32'(ready), 32'h1);
    check("mem0", 32'(mem[0]), 32'h0000BEEF);
    check("mem1", 32'(mem[1]), 32'h0000DEAD);
    @(posedge clk);
    #1;

    access(1'b1, 1'b0, 32'd1024, 32'h0, 32'hDEADBEEF);

    // Simultaneous read and write behaves as a write only
    access(1'b1, 1'b1, 32'd1028, 32'h12345678, 32'hDEADBEEF);
    @(negedge clk);
    check("mem2", 32'(mem[2]), 32'h00005678);
    check("mem3", 32'(mem[3]), 32'h00001234);
    check("read_data_kept", read_data, 32'hDEADBEEF);
    @(posedge clk);
    #1;

    // Reset asserted during the first HIGH cycle of a write
    wr_en      = 1'b1;
    address    = 32'd1032;
    write_data = 32'h0000FFFF;
    repeat (W + 1) @(posedge clk);
    #1;
    rst   = 1'b0;
    wr_en = 1'b0;
    #1;
    check("mid_rst_we_n", 32'(sram_we_n), 32'h1);
    check("mid_rst_oe", 32'(sram_dq_oe), 32'h0);
    check("mid_rst_addr", 32'(sram_addr), 32'h0);
    check("mid_rst_read_data", read_data, 32'h0);
    check("mid_rst_ready", 32'(ready), 32'h1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(ready), 32'h1);
    check("mem4", 32'(mem[4]), 32'h0000FFFF);
    check("mem5", 32'(mem[5]), 32'h0000A005);
    @(posedge clk);
    #1;

    // Back-to-back reads: second one starts in the IDLE cycle right after DONE
    access(1'b1, 1'b0, 32'd1024, 32'h0, 32'hDEADBEEF);
    access(1'b1, 1'b0, 32'd1060, 32'h0, 32'hA013A012);

    // Address below the base wraps to the top of the SRAM
    access(1'b1, 1'b0, 32'd1020, 32'h0, 32'hA03FA03E);
    @(negedge clk);
    check("final_ready", 32'(ready), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, %0d checks so far", n_tests);
    $fatal(1, "timeout");
  end

endmodule
